// File: rtl/register_file_scoreboard.sv
// Register file with per-register busy scoreboard, two combinational read ports, optional writeback forwarding.
// Reads are zero-latency, writes/reservations land at the next edge; a reservation on a busy register stalls (issue_ready=0) until its writeback.
module register_file_scoreboard #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int BYPASS     = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [ADDR_WIDTH-1:0] rs_index,
    output logic [DATA_WIDTH-1:0] rs_data,
    output logic                  rs_busy,
    input  logic [ADDR_WIDTH-1:0] rt_index,
    output logic [DATA_WIDTH-1:0] rt_data,
    output logic                  rt_busy,
    input  logic                  issue_valid,
    input  logic [ADDR_WIDTH-1:0] issue_index,
    output logic                  issue_ready,
    input  logic                  wb_valid,
    input  logic [ADDR_WIDTH-1:0] wb_index,
    input  logic [DATA_WIDTH-1:0] wb_data,
    output logic [DATA_WIDTH-1:0] register_v0,
    output logic [ADDR_WIDTH:0]   busy_count,
    output logic                  wb_error
);
    localparam int NUM_REGS = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [NUM_REGS-1:0]   busy_q, busy_d;
    logic [ADDR_WIDTH:0]   busy_count_q, busy_count_d;
    logic                  wb_error_q, wb_error_d;

    logic wb_nz, issue_set, wb_clr, rs_hit, rt_hit;

    always_comb begin
        rs_hit = (BYPASS != 0) && wb_valid && (wb_index == rs_index);
        rt_hit = (BYPASS != 0) && wb_valid && (wb_index == rt_index);
        rs_data = '0;
        rt_data = '0;
        // Register 0 is never stored, but force it to read zero regardless of forwarding.
        if (reset_n && rs_index != '0) rs_data = rs_hit ? wb_data : regs_q[rs_index];
        if (reset_n && rt_index != '0) rt_data = rt_hit ? wb_data : regs_q[rt_index];
        rs_busy = busy_q[rs_index] && !rs_hit;
        rt_busy = busy_q[rt_index] && !rt_hit;
    end

    always_comb begin
        wb_nz       = wb_valid && (wb_index != '0);
        issue_ready = (issue_index == '0) || !busy_q[issue_index] ||
                      (wb_valid && (wb_index == issue_index));
        issue_set   = issue_valid && issue_ready && (issue_index != '0);
        wb_clr      = wb_nz && busy_q[wb_index];
        wb_error_d  = wb_valid && ((wb_index == '0) || !busy_q[wb_index]);

        // Clear before set so a same-index issue and writeback leaves the new reservation standing.
        busy_d = busy_q;
        if (wb_nz)     busy_d[wb_index]    = 1'b0;
        if (issue_set) busy_d[issue_index] = 1'b1;

        busy_count_d = busy_count_q;
        case ({issue_set, wb_clr})
            2'b10:   busy_count_d = busy_count_q + 1'b1;
            2'b01:   busy_count_d = busy_count_q - 1'b1;
            default: busy_count_d = busy_count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
            busy_q       <= '0;
            busy_count_q <= '0;
            wb_error_q   <= 1'b0;
        end else begin
            if (wb_nz) regs_q[wb_index] <= wb_data;
            busy_q       <= busy_d;
            busy_count_q <= busy_count_d;
            wb_error_q   <= wb_error_d;
        end
    end

    assign register_v0 = regs_q[2];
    assign busy_count  = busy_count_q;
    assign wb_error    = wb_error_q;

endmodule

// File: tb/tb_register_file_scoreboard.sv
module tb_register_file_scoreboard;
    logic        clk = 1'b0;
    logic        reset_n;
    logic [4:0]  rs_index, rt_index, issue_index, wb_index;
    logic        issue_valid, wb_valid;
    logic [31:0] wb_data;

    logic [31:0] a_rs_data, a_rt_data, a_v0, n_rs_data, n_rt_data, n_v0;
    logic        a_rs_busy, a_rt_busy, a_ready, a_err, n_rs_busy, n_rt_busy, n_ready, n_err;
    logic [5:0]  a_cnt, n_cnt;

    int checks = 0;
    int errors = 0;
    bit started = 1'b0;

    always #5 clk = ~clk;

    register_file_scoreboard #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .BYPASS(1)) dut (
        .clk(clk), .reset_n(reset_n),
        .rs_index(rs_index), .rs_data(a_rs_data), .rs_busy(a_rs_busy),
        .rt_index(rt_index), .rt_data(a_rt_data), .rt_busy(a_rt_busy),
        .issue_valid(issue_valid), .issue_index(issue_index), .issue_ready(a_ready),
        .wb_valid(wb_valid), .wb_index(wb_index), .wb_data(wb_data),
        .register_v0(a_v0), .busy_count(a_cnt), .wb_error(a_err)
    );

    register_file_scoreboard #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .BYPASS(0)) dut_nb (
        .clk(clk), .reset_n(reset_n),
        .rs_index(rs_index), .rs_data(n_rs_data), .rs_busy(n_rs_busy),
        .rt_index(rt_index), .rt_data(n_rt_data), .rt_busy(n_rt_busy),
        .issue_valid(issue_valid), .issue_index(issue_index), .issue_ready(n_ready),
        .wb_valid(wb_valid), .wb_index(wb_index), .wb_data(wb_data),
        .register_v0(n_v0), .busy_count(n_cnt), .wb_error(n_err)
    );

    // Reference model: architectural contents, reservation set and error flag.
    bit [31:0] m_regs [32];
    bit        m_busy [32];
    bit        m_err;

    function automatic bit m_ready();
        return (issue_index == 0) || !m_busy[issue_index] || (wb_valid && wb_index == issue_index);
    endfunction

    function automatic int m_count();
        int n = 0;
        for (int i = 0; i < 32; i++) n += int'(m_busy[i]);
        return n;
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] idx, input bit byp);
        if (!reset_n || idx == 0) return 32'h0;
        if (byp && wb_valid && wb_index == idx) return wb_data;
        return m_regs[idx];
    endfunction

    function automatic logic m_rbusy(input logic [4:0] idx, input bit byp);
        return m_busy[idx] && !(byp && wb_valid && wb_index == idx);
    endfunction

    always @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < 32; i++) begin
                m_regs[i] = 32'h0;
                m_busy[i] = 1'b0;
            end
            m_err = 1'b0;
        end else begin
            bit rdy;
            rdy   = m_ready();
            m_err = wb_valid && (wb_index == 0 || !m_busy[wb_index]);
            if (wb_valid && wb_index != 0) begin
                m_regs[wb_index] = wb_data;
                m_busy[wb_index] = 1'b0;
            end
            if (issue_valid && rdy && issue_index != 0) m_busy[issue_index] = 1'b1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (started) begin
            check("a_rs_data", a_rs_data, m_read(rs_index, 1'b1));
            check("a_rt_data", a_rt_data, m_read(rt_index, 1'b1));
            check("n_rs_data", n_rs_data, m_read(rs_index, 1'b0));
            check("n_rt_data", n_rt_data, m_read(rt_index, 1'b0));
            check("a_rs_busy", 32'(a_rs_busy), 32'(m_rbusy(rs_index, 1'b1)));
            check("a_rt_busy", 32'(a_rt_busy), 32'(m_rbusy(rt_index, 1'b1)));
            check("n_rs_busy", 32'(n_rs_busy), 32'(m_rbusy(rs_index, 1'b0)));
            check("n_rt_busy", 32'(n_rt_busy), 32'(m_rbusy(rt_index, 1'b0)));
            check("a_ready", 32'(a_ready), 32'(m_ready()));
            check("n_ready", 32'(n_ready), 32'(m_ready()));
            check("a_cnt", 32'(a_cnt), 32'(m_count()));
            check("n_cnt", 32'(n_cnt), 32'(m_count()));
            check("a_err", 32'(a_err), 32'(m_err));
            check("n_err", 32'(n_err), 32'(m_err));
            check("a_v0", a_v0, m_regs[2]);
            check("n_v0", n_v0, m_regs[2]);
        end
    end

    task automatic drive(input bit iv, input logic [4:0] ii, input bit wv, input logic [4:0] wi,
                         input logic [31:0] wd, input logic [4:0] rs, input logic [4:0] rt);
        issue_valid = iv; issue_index = ii;
        wb_valid = wv; wb_index = wi; wb_data = wd;
        rs_index = rs; rt_index = rt;
        @(negedge clk);
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n = 1'b0;
        issue_valid = 1'b0; issue_index = '0; wb_valid = 1'b0; wb_index = '0; wb_data = '0;
        rs_index = '0; rt_index = '0;
        @(posedge clk);
        started = 1'b1;
        next();
        next();
        reset_n = 1'b1;

        drive(0, 13, 0, 0, 0, 0, 0);
        check("rst_v0", a_v0, 32'h0);
        check("rst_cnt", 32'(a_cnt), 32'd0);
        check("rst_err", 32'(a_err), 32'd0);
        check("rst_ready", 32'(a_ready), 32'd1);
        next();
        drive(0, 0, 1, 5, 32'hDEADBEEF, 5, 0);
        check("wb5_fwd", a_rs_data, 32'hDEADBEEF);
        check("wb5_nofwd", n_rs_data, 32'h0);
        next();
        drive(0, 0, 0, 0, 0, 5, 0);
        check("wb5_err", 32'(a_err), 32'd1);
        check("wb5_read", a_rs_data, 32'hDEADBEEF);
        next();
        drive(1, 7, 0, 0, 0, 5, 0);
        check("wb5_err_clr", 32'(a_err), 32'd0);
        check("iss7_ready", 32'(a_ready), 32'd1);
        next();
        drive(1, 7, 0, 0, 0, 7, 0);
        check("iss7_again", 32'(a_ready), 32'd0);
        check("iss7_cnt", 32'(a_cnt), 32'd1);
        check("iss7_busy", 32'(a_rs_busy), 32'd1);
        next();
        drive(0, 0, 1, 7, 32'h12345678, 7, 0);
        check("wb7_fwd", a_rs_data, 32'h12345678);
        check("wb7_busy", 32'(a_rs_busy), 32'd0);
        check("wb7_nb_busy", 32'(n_rs_busy), 32'd1);
        next();
        drive(1, 3, 0, 0, 0, 7, 0);
        check("wb7_cnt", 32'(a_cnt), 32'd0);
        check("wb7_err", 32'(a_err), 32'd0);
        next();
        drive(1, 3, 1, 3, 32'hA5A5A5A5, 3, 0);
        check("r3_ready", 32'(a_ready), 32'd1);
        check("r3_cnt0", 32'(a_cnt), 32'd1);
        next();
        drive(0, 0, 0, 0, 0, 3, 0);
        check("r3_cnt1", 32'(a_cnt), 32'd1);
        check("r3_err", 32'(a_err), 32'd0);
        check("r3_data", a_rs_data, 32'hA5A5A5A5);
        check("r3_busy", 32'(a_rs_busy), 32'd1);
        next();
        drive(0, 0, 1, 3, 32'h11, 3, 0);
        next();
        drive(0, 0, 1, 0, 32'hFFFFFFFF, 0, 0);
        check("r0_cnt", 32'(a_cnt), 32'd0);
        check("r0_rs", a_rs_data, 32'h0);
        check("r0_rt", a_rt_data, 32'h0);
        next();
        drive(1, 0, 0, 0, 0, 0, 0);
        check("r0_err", 32'(a_err), 32'd1);
        check("r0_ready", 32'(a_ready), 32'd1);
        next();
        drive(0, 0, 0, 0, 0, 0, 0);
        check("r0_cnt_after", 32'(a_cnt), 32'd0);
        check("r0_err_clr", 32'(a_err), 32'd0);
        next();
        drive(1, 1, 0, 0, 0, 0, 0); next();
        drive(1, 2, 0, 0, 0, 0, 0); next();
        drive(1, 4, 0, 0, 0, 0, 0); next();
        drive(0, 0, 1, 2, 32'h55, 0, 0);
        check("res3_cnt", 32'(a_cnt), 32'd3);
        next();
        drive(0, 0, 0, 0, 0, 0, 0);
        check("v0_55", a_v0, 32'h55);
        check("v0_cnt", 32'(a_cnt), 32'd2);
        next();
        reset_n = 1'b0;
        drive(1, 6, 1, 4, 32'h99, 4, 1);
        check("inrst_rs", a_rs_data, 32'h0);
        check("inrst_rt", a_rt_data, 32'h0);
        check("inrst_nb_rs", n_rs_data, 32'h0);
        next();
        reset_n = 1'b1;
        drive(0, 1, 0, 0, 0, 2, 4);
        check("postrst_cnt", 32'(a_cnt), 32'd0);
        check("postrst_v0", a_v0, 32'h0);
        check("postrst_rs", a_rs_data, 32'h0);
        check("postrst_rt", a_rt_data, 32'h0);
        check("postrst_ready", 32'(a_ready), 32'd1);
        next();
        drive(1, 9, 0, 0, 0, 0, 0);
        next();
        drive(0, 0, 1, 9, 32'h77, 0, 9);
        check("nb_rt_old", n_rt_data, 32'h0);
        check("nb_rt_busy", 32'(n_rt_busy), 32'd1);
        check("byp_rt_new", a_rt_data, 32'h77);
        check("byp_rt_busy", 32'(a_rt_busy), 32'd0);
        next();
        drive(0, 0, 0, 0, 0, 0, 9);
        check("nb_rt_next", n_rt_data, 32'h77);
        check("r9_cnt", 32'(a_cnt), 32'd0);
        next();

        // Overlapping issue/writeback traffic, with one reset in the middle, checked against the model.
        for (int k = 0; k < 32; k++) begin
            reset_n = (k != 17);
            drive(k % 4 != 3, 5'((k * 5 + 1) % 16), k % 3 != 0, 5'((k * 7) % 16),
                  32'(k) * 32'h01010101 + 32'h0F, 5'((k * 5 + 1) % 16), 5'((k * 7 + 2) % 16));
            next();
        end
        reset_n = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);
        next();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/register_file_scoreboard.md
REGISTER_FILE_SCOREBOARD -- requirements
Module: register_file_scoreboard

Interface
REQ-001 Parameter DATA_WIDTH, default 32, SHALL set the width of every register and data port.
REQ-002 Parameter ADDR_WIDTH, default 5, SHALL set index width; NUM_REGS = 2**ADDR_WIDTH; legal range 2..6.
REQ-003 Parameter BYPASS, default 1, SHALL enable (1) or disable (0) writeback-to-read forwarding.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 One clock; reset is synchronous and active-low: reset_n  input  1  sampled on rising clk edge, 0 = reset.
REQ-006 rs_index  input  ADDR_WIDTH  read port A index.
REQ-007 rs_data  output  DATA_WIDTH  read port A data, combinational.
REQ-008 rs_busy  output  1  port A register has outstanding reservation.
REQ-009 rt_index / rt_data / rt_busy  as REQ-006..008 for read port B.
REQ-010 issue_valid  input  1  request to reserve destination issue_index.
REQ-011 issue_index  input  ADDR_WIDTH  destination being reserved.
REQ-012 issue_ready  output  1  reservation accepted this cycle when high with issue_valid.
REQ-013 wb_valid  input  1  writeback strobe.
REQ-014 wb_index  input  ADDR_WIDTH  writeback destination.
REQ-015 wb_data  input  DATA_WIDTH  writeback value.
REQ-016 register_v0  output  DATA_WIDTH  stored content of register 2, never forwarded.
REQ-017 busy_count  output  ADDR_WIDTH+1  registered count of busy registers.
REQ-018 wb_error  output  1  registered one-cycle pulse flagging illegal writeback.

Function
REQ-019 Register 0 SHALL read as 0 on both ports, never be stored to, and never be busy.
REQ-020 Reads SHALL be combinational: rs_data = regs[rs_index]; while reset_n=0 rs_data and rt_data SHALL be 0.
REQ-021 With BYPASS=1, wb_valid=1, wb_index=rs_index!=0: rs_data SHALL equal wb_data same cycle; likewise rt.
REQ-022 rs_busy = busy[rs_index] AND NOT (wb_valid AND wb_index=rs_index AND BYPASS=1); likewise rt; BYPASS=0 reports raw busy bit.
REQ-023 issue_ready SHALL be 1 when issue_index=0, or busy[issue_index]=0, or a same-cycle wb_valid targets issue_index.
REQ-024 issue_valid AND issue_ready with issue_index!=0 SHALL set busy[issue_index] at next edge; issue_index=0 accepted, no state change.
REQ-025 issue_valid with issue_ready=0 SHALL change nothing; requester holds and retries (no queuing).
REQ-026 wb_valid with wb_index!=0 SHALL write wb_data and clear busy[wb_index] at next edge.
REQ-027 Same-cycle accepted issue and wb to the same index: data written, busy ends set (new reservation wins).
REQ-028 wb_valid with wb_index=0, or to a register whose busy bit is 0, SHALL set wb_error for exactly the next cycle; non-zero index still writes.
REQ-029 busy_count SHALL track popcount of busy bits: +1 set only, -1 clear only, unchanged for both/neither; never exceeds NUM_REGS-1.
REQ-030 Write latency 1 cycle: data written at edge N readable from stored array in cycle N+1.

Reset
REQ-031 reset_n=0 at an edge SHALL clear all registers, all busy bits, busy_count and wb_error to 0, overriding same-cycle issue/wb.
REQ-032 Reset mid-operation SHALL discard all outstanding reservations; issue_ready=1 for any index in first cycle after reset.
REQ-033 register_v0 SHALL read 0 in the cycle after reset.

Verification
REQ-034 Reset, then wb r5=0xDEADBEEF (not reserved) -> wb_error=1 next cycle only; rs_index=5 reads 0xDEADBEEF.
REQ-035 Issue r7; next cycle issue r7 again -> issue_ready=0, busy_count=1; wb r7=0x12345678 with rs_index=7 same cycle -> rs_data=0x12345678, rs_busy=0, busy_count=0 after.
REQ-036 Issue r3 and wb r3=0xA5A5A5A5 same cycle (r3 busy) -> r3=0xA5A5A5A5, busy[3]=1, busy_count unchanged at 1, wb_error=0.
REQ-037 wb r0=0xFFFFFFFF -> r0 still reads 0, wb_error pulses 1 cycle; issue r0 -> issue_ready=1, busy_count unchanged.
REQ-038 Reserve r1,r2,r4 (busy_count=3), wb r2=0x55 (register_v0=0x55), then reset_n=0 one edge -> busy_count=0, register_v0=0, all reads 0.
REQ-039 BYPASS=0 instance: wb r9=0x77 with rt_index=9 same cycle -> rt_data=old value 0, rt_busy raw; 0x77 visible next cycle.
